// File: rtl/plic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plic_pkg                                                              |
// | Shared defaults, register offsets and FSM state types for plic_lite.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`ifndef PLIC_AXI_ADDR_WIDTH
`define PLIC_AXI_ADDR_WIDTH 12
`endif

package plic_pkg;
    localparam int NUM_SRC_DEF = 8;
    localparam int PRIO_W_DEF  = 3;
    localparam int AXI_ADDR_W  = `PLIC_AXI_ADDR_WIDTH;

    localparam logic [AXI_ADDR_W-1:0] OFF_PENDING = AXI_ADDR_W'(12'h080);
    localparam logic [AXI_ADDR_W-1:0] OFF_ENABLE  = AXI_ADDR_W'(12'h100);
    localparam logic [AXI_ADDR_W-1:0] OFF_THRESH  = AXI_ADDR_W'(12'h200);
    localparam logic [AXI_ADDR_W-1:0] OFF_CLAIM   = AXI_ADDR_W'(12'h204);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;
endpackage

`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plic_gateway                                                          |
// | Per-source synchronizer plus pending / in-flight tracking.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);
    logic sync1_q, sync2_q;
    logic pending_q, pending_d;
    logic in_flight_q, in_flight_d;

    // A claim only happens while pending (hence not in flight), so a
    // coincident complete is a no-op and the claim wins on in_flight.
    always_comb begin
        pending_d = pending_q;
        if (sync2_q && !pending_q && !in_flight_q) begin
            pending_d = 1'b1;
        end
        if (claim_i) begin
            pending_d = 1'b0;
        end
        in_flight_d = in_flight_q;
        if (complete_i) begin
            in_flight_d = 1'b0;
        end
        if (claim_i) begin
            in_flight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pending_q   <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            sync1_q     <= irq_i;
            sync2_q     <= sync1_q;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign pending_o = pending_q;
endmodule

`default_nettype wire

// File: rtl/plic_lite.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plic_lite                                                             |
// | Single-context PLIC: gateways, arbitration, AXI4-Lite register slave. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module plic_lite
    import plic_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              irq_src_i,
    output logic                            ext_int_req_o,
    input  logic [`PLIC_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [31:0]                     S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [`PLIC_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [31:0]                     S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC:1][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC:1]             enable_q, enable_d;
    logic [PRIO_W-1:0]            thresh_q, thresh_d;
    logic [NUM_SRC:1]             pending, claim_vec, complete_vec;
    logic [ID_W-1:0]              best_id;
    logic [PRIO_W-1:0]            best_prio;
    logic                         ext_int_d, ext_int_q;
    logic [31:0]                  rd_data;

    wr_state_e   wr_state_q;
    rd_state_e   rd_state_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic        wr_fire, wr_en, rd_fire;
    logic        unused_ok;

    assign wr_fire = (wr_state_q == W_IDLE) && awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_en   = wr_fire && (S_AXI_WSTRB == 4'hF);
    assign rd_fire = (rd_state_q == R_IDLE) && arready_q && S_AXI_ARVALID;

    for (genvar k = 1; k <= NUM_SRC; k++) begin : g_gw
        plic_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .irq_i      (irq_src_i[k-1]),
            .claim_i    (claim_vec[k]),
            .complete_i (complete_vec[k]),
            .pending_o  (pending[k])
        );
    end

    // Strict '>' while scanning upward keeps the lowest ID on ties and
    // excludes priority 0 for free.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        ext_int_d = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (pending[k] && enable_q[k]) begin
                if (prio_q[k] > best_prio) begin
                    best_prio = prio_q[k];
                    best_id   = ID_W'(k);
                end
                if (prio_q[k] > thresh_q) begin
                    ext_int_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        prio_d       = prio_q;
        enable_d     = enable_q;
        thresh_d     = thresh_q;
        complete_vec = '0;
        if (wr_en) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (S_AXI_AWADDR == AXI_ADDR_W'(4 * k)) begin
                    prio_d[k] = S_AXI_WDATA[PRIO_W-1:0];
                end
                if ((S_AXI_AWADDR == OFF_CLAIM) && (S_AXI_WDATA == 32'(k))) begin
                    complete_vec[k] = 1'b1;
                end
            end
            if (S_AXI_AWADDR == OFF_ENABLE) begin
                enable_d = S_AXI_WDATA[NUM_SRC:1];
            end
            if (S_AXI_AWADDR == OFF_THRESH) begin
                thresh_d = S_AXI_WDATA[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        rd_data   = '0;
        claim_vec = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (S_AXI_ARADDR == AXI_ADDR_W'(4 * k)) begin
                rd_data[PRIO_W-1:0] = prio_q[k];
            end
            if (rd_fire && (S_AXI_ARADDR == OFF_CLAIM) && (best_id == ID_W'(k))) begin
                claim_vec[k] = 1'b1;
            end
        end
        case (S_AXI_ARADDR)
            OFF_PENDING: rd_data[NUM_SRC:1]  = pending;
            OFF_ENABLE:  rd_data[NUM_SRC:1]  = enable_q;
            OFF_THRESH:  rd_data[PRIO_W-1:0] = thresh_q;
            OFF_CLAIM:   rd_data[ID_W-1:0]   = best_id;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= '0;
            enable_q  <= '0;
            thresh_q  <= '0;
            ext_int_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            thresh_q  <= thresh_d;
            ext_int_q <= ext_int_d;
        end
    end

    // Ready is raised one cycle after both valids appear, so the
    // handshake edge is the cycle in which ready is already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (wr_fire) begin
                            bvalid_q   <= 1'b1;
                            wr_state_q <= W_RESP;
                        end
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase

            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q) begin
                        arready_q <= 1'b0;
                        if (rd_fire) begin
                            rdata_q    <= rd_data;
                            rvalid_q   <= 1'b1;
                            rd_state_q <= R_DATA;
                        end
                    end else if (S_AXI_ARVALID) begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign ext_int_req_o = ext_int_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT};
endmodule

`default_nettype wire

// File: tb/tb_plic_lite.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_plic_lite                                                          |
// | Directed scoreboard bench for plic_lite.                              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`ifndef PLIC_AXI_ADDR_WIDTH
`define PLIC_AXI_ADDR_WIDTH 12
`endif

module tb_plic_lite;
    localparam int NS = 8;
    localparam int PW = 3;
    localparam int AW = `PLIC_AXI_ADDR_WIDTH;

    localparam logic [AW-1:0] A_PEND  = AW'(12'h080);
    localparam logic [AW-1:0] A_EN    = AW'(12'h100);
    localparam logic [AW-1:0] A_THR   = AW'(12'h200);
    localparam logic [AW-1:0] A_CLAIM = AW'(12'h204);

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] irq;
    logic          ext_int;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [31:0]   rdata;
    logic [1:0]    bresp, rresp;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    plic_lite #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src_i     (irq),
        .ext_int_req_o (ext_int),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_view();
        return {23'b0, dut.pending, 1'b0};
    endfunction

    function automatic logic [AW-1:0] prio_addr(input int k);
        return AW'(4 * k);
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_arready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        if (!arready) check("arready_timeout", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 50);
        check("rvalid", 32'(rvalid), 32'd1);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 50);
        if (!awready) check("awready_timeout", 32'(awready), 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 50);
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
    endtask

    // Expected data is queued at issue and retired when RVALID shows up.
    task automatic axi_read(input string tag, input logic [AW-1:0] addr,
                            input logic [31:0] exp, input int hold);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        wait_arready();
        wait_rvalid();
        if (hold > 0) begin
            arvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                check("hold_rvalid", 32'(rvalid), 32'd1);
                check("hold_rdata", rdata, exp);
                check("hold_arready", 32'(arready), 32'd0);
                @(negedge clk);
            end
            arvalid = 1'b0;
            rready  = 1'b1;
        end
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
        if (rresp != 2'b00) check("rresp", 32'(rresp), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed time limit, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; irq = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        do_reset();

        check("rst_ext", 32'(ext_int), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        axi_read("rst_prio1", prio_addr(1), 32'd0, 0);
        axi_read("rst_enable", A_EN, 32'd0, 0);

        // Gateway latency and the registered interrupt request
        axi_write(prio_addr(3), 32'd2, 4'hF);
        axi_write(A_EN, 32'h008, 4'hF);
        axi_write(A_THR, 32'd1, 4'hF);
        axi_read("prio3", prio_addr(3), 32'd2, 0);
        @(posedge clk); #1;
        irq[2] = 1'b1;
        tick(2);
        check("pend_n2", pend_view(), 32'h0);
        tick(1);
        check("pend_n3", pend_view(), 32'h8);
        check("ext_n3", 32'(ext_int), 32'd0);
        tick(1);
        check("ext_n4", 32'(ext_int), 32'd1);
        axi_read("pend_reg", A_PEND, 32'h008, 0);

        // Equal priorities: lowest ID first
        irq = '0;
        do_reset();
        axi_write(prio_addr(2), 32'd5, 4'hF);
        axi_write(prio_addr(5), 32'd5, 4'hF);
        axi_write(A_EN, 32'h024, 4'hF);
        irq[1] = 1'b1; irq[4] = 1'b1;
        tick(5);
        axi_read("claim_tie", A_CLAIM, 32'd2, 0);
        axi_read("pend_after_claim", A_PEND, 32'h020, 0);
        axi_read("claim_second", A_CLAIM, 32'd5, 0);
        axi_read("claim_empty", A_CLAIM, 32'd0, 0);
        axi_read("pend_empty", A_PEND, 32'h000, 0);

        // Claim / complete with the source held high
        irq = '0;
        do_reset();
        axi_write(prio_addr(3), 32'd1, 4'hF);
        axi_write(A_EN, 32'h008, 4'hF);
        irq[2] = 1'b1;
        tick(5);
        axi_read("claim3", A_CLAIM, 32'd3, 0);
        tick(6);
        check("no_repend", pend_view(), 32'h0);
        axi_write(A_CLAIM, 32'd3, 4'hF);
        check("repend_before", pend_view(), 32'h0);
        @(posedge clk); #1;
        check("repend_after", pend_view(), 32'h8);
        axi_write(A_CLAIM, 32'd9, 4'hF);
        axi_read("claim3_again", A_CLAIM, 32'd3, 0);

        // Threshold gates the request, not the claim
        irq = '0;
        do_reset();
        axi_write(A_THR, 32'd5, 4'hF);
        axi_write(prio_addr(1), 32'd5, 4'hF);
        axi_write(A_EN, 32'h002, 4'hF);
        irq[0] = 1'b1;
        tick(6);
        check("thr_ext", 32'(ext_int), 32'd0);
        axi_read("thr_claim", A_CLAIM, 32'd1, 0);

        // Read back-pressure and partial-strobe write
        irq = '0;
        do_reset();
        axi_write(A_EN, 32'h0FE, 4'hF);
        axi_read("hold_en", A_EN, 32'h0FE, 4);
        axi_write(A_EN, 32'h000, 4'h3);
        axi_read("strb_en", A_EN, 32'h0FE, 0);

        // Reset while a read response is outstanding
        axi_write(prio_addr(1), 32'd7, 4'hF);
        axi_write(A_THR, 32'd3, 4'hF);
        irq[0] = 1'b1;
        tick(6);
        check("pre_rst_ext", 32'(ext_int), 32'd1);
        araddr  = A_EN;
        arvalid = 1'b1;
        rready  = 1'b0;
        wait_arready();
        wait_rvalid();
        irq = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_ext", 32'(ext_int), 32'd0);
        check("mid_rst_pend", pend_view(), 32'h0);
        rready = 1'b1;
        axi_read("mid_rst_en", A_EN, 32'd0, 0);
        axi_read("mid_rst_thr", A_THR, 32'd0, 0);
        axi_read("mid_rst_prio1", prio_addr(1), 32'd0, 0);

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
